// File: rtl/bus_pkg.sv
// Shared types and sizing for the LSU / debug-port slave bus arbiter.
package bus_pkg;

  localparam int BUS_AW      = 32;
  localparam int BUS_DW      = 32;
  localparam int TIMEOUT_DEF = 16;
  localparam int TIMEOUT_W   = $clog2(TIMEOUT_DEF + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                  we;
    logic [BUS_AW-1:0]     addr;
    logic [BUS_DW-1:0]     wdata;
    logic [BUS_DW/8-1:0]   wstrb;
  } bus_cmd_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/lsu_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker; the pointer remembers the last granted master
// and only moves when a grant is actually issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    if (grant_en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Reset points at m1 so m0 wins the first contended pick.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last <= 1'b1;
    end else if (|gnt) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/lsu_bus_arbiter.sv
// Shares one data-memory/MMIO slave bus between the core LSU (m0) and the
// debug/loader port (m1); one transaction at a time with ack timeout.
module lsu_bus_arbiter
  import bus_pkg::*;
#(
  parameter int AW      = BUS_AW,
  parameter int DW      = BUS_DW,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [1:0]              m_req,
  input  logic [1:0]              m_we,
  input  logic [1:0][AW-1:0]      m_addr,
  input  logic [1:0][DW-1:0]      m_wdata,
  input  logic [1:0][DW/8-1:0]    m_wstrb,
  output logic [1:0]              m_gnt,
  output logic [1:0]              m_rvalid,
  output logic [DW-1:0]           m_rdata,
  output logic                    m_err,
  output logic                    s_req,
  output logic                    s_we,
  output logic [AW-1:0]           s_addr,
  output logic [DW-1:0]           s_wdata,
  output logic [DW/8-1:0]         s_wstrb,
  input  logic                    s_ack,
  input  logic [DW-1:0]           s_rdata,
  output logic                    busy,
  output logic                    spurious
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e       state;
  bus_cmd_t         cmd_q;
  bus_cmd_t         cmd_in;
  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic             s_req_q;
  logic [1:0]       rvalid_q;
  logic [DW-1:0]    rdata_q;
  logic             err_q;
  logic             spurious_q;
  logic             grant_en;
  logic [1:0]       gnt;
  logic             sel;

  // Grants are suppressed while in reset so nothing is captured on that edge.
  assign grant_en = rstn && (state == IDLE);

  rr_arb2 u_rr (
    .clk      (clk),
    .rstn     (rstn),
    .req      (m_req),
    .grant_en (grant_en),
    .gnt      (gnt)
  );

  assign sel = gnt[1];

  always_comb begin
    cmd_in       = '0;
    cmd_in.we    = m_we[sel];
    cmd_in.addr  = m_addr[sel];
    cmd_in.wdata = m_wdata[sel];
    cmd_in.wstrb = m_wstrb[sel];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      cmd_q      <= '0;
      owner      <= 1'b0;
      cnt        <= '0;
      s_req_q    <= 1'b0;
      rvalid_q   <= 2'b00;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      rvalid_q <= 2'b00;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      if (s_ack && (state == IDLE)) begin
        spurious_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (|gnt) begin
            cmd_q   <= cmd_in;
            owner   <= sel;
            cnt     <= CNT_W'(1);
            s_req_q <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          // An ack arriving on the timeout cycle still completes cleanly.
          if (s_ack) begin
            rvalid_q <= onehot2(owner);
            rdata_q  <= s_rdata;
            s_req_q  <= 1'b0;
            state    <= IDLE;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            rvalid_q <= onehot2(owner);
            err_q    <= 1'b1;
            s_req_q  <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_gnt    = gnt;
  assign m_rvalid = rvalid_q;
  assign m_rdata  = rdata_q;
  assign m_err    = err_q;
  assign s_req    = s_req_q;
  assign s_we     = cmd_q.we;
  assign s_addr   = cmd_q.addr;
  assign s_wdata  = cmd_q.wdata;
  assign s_wstrb  = cmd_q.wstrb;
  assign busy     = (state == BUSY);
  assign spurious = spurious_q;

endmodule

// File: tb/tb_lsu_bus_arbiter.sv
// Directed bench for lsu_bus_arbiter; responses are checked by a scoreboard monitor.
module tb_lsu_bus_arbiter;

  localparam int TMO = 16;

  logic              clk;
  logic              rstn;
  logic [1:0]        m_req;
  logic [1:0]        m_we;
  logic [1:0][31:0]  m_addr;
  logic [1:0][31:0]  m_wdata;
  logic [1:0][3:0]   m_wstrb;
  logic [1:0]        m_gnt;
  logic [1:0]        m_rvalid;
  logic [31:0]       m_rdata;
  logic              m_err;
  logic              s_req;
  logic              s_we;
  logic [31:0]       s_addr;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_ack;
  logic [31:0]       s_rdata;
  logic              busy;
  logic              spurious;

  lsu_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .m_err(m_err), .s_req(s_req), .s_we(s_we),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_ack(s_ack),
    .s_rdata(s_rdata), .busy(busy), .spurious(spurious)
  );

  typedef struct {
    int          m;
    logic [31:0] d;
    logic        e;
    int          c;
  } rsp_t;

  rsp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;
  logic auto_ack = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (m_rvalid !== 2'b00) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rvalid: got %b expected none (cycle %0d)", m_rvalid, cyc);
        end else begin
          rsp_t e;
          e = sbq.pop_front();
          chk("rsp_master", m_rvalid, (e.m == 1) ? 2'b10 : 2'b01);
          chk("rsp_rdata", m_rdata, e.d);
          chk("rsp_err", m_err, e.e);
          chk("rsp_cycle", cyc, e.c);
        end
      end else begin
        chk("idle_rdata", m_rdata, 0);
        chk("idle_err", m_err, 0);
      end
    end
  end

  // Slave that acks in the first BUSY cycle, returning data derived from the address.
  always @(posedge clk) begin
    #2;
    if (auto_ack) begin
      s_ack   = s_req;
      s_rdata = s_req ? {16'hBEEF, s_addr[15:0]} : 32'h0;
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, m_gnt, 0);
    chk({tag, "_rvalid"}, m_rvalid, 0);
    chk({tag, "_rdata"}, m_rdata, 0);
    chk({tag, "_err"}, m_err, 0);
    chk({tag, "_sreq"}, s_req, 0);
    chk({tag, "_swe"}, s_we, 0);
    chk({tag, "_saddr"}, s_addr, 0);
    chk({tag, "_swdata"}, s_wdata, 0);
    chk({tag, "_swstrb"}, s_wstrb, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_spurious"}, spurious, 0);
  endtask

  task automatic run_alternation(input int n);
    int prev;
    logic got;
    auto_ack   = 1'b1;
    m_we       = 2'b00;
    m_addr[0]  = 32'h0000_7000;
    m_addr[1]  = 32'h0000_7010;
    m_wdata    = '0;
    m_wstrb    = '0;
    m_req      = 2'b11;
    prev = -1;
    for (int g = 0; g < n; g++) begin
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        if (m_gnt != 2'b00) got = 1'b1;
      end
      chk("alt_grant_seen", got, 1);
      if (!got) break;
      chk("alt_grant_order", m_gnt, (g % 2 == 1) ? 2'b10 : 2'b01);
      if (prev >= 0) chk("alt_grant_gap", cyc - prev, 2);
      prev = cyc;
      sbq.push_back('{(g % 2), {16'hBEEF, ((g % 2 == 1) ? 16'h7010 : 16'h7000)}, 1'b0, cyc + 2});
      if (g == n - 1) begin
        @(posedge clk); #1;
        m_req = 2'b00;
      end
    end
    m_req = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    auto_ack = 1'b0;
    s_ack    = 1'b0;
    s_rdata  = '0;
  endtask

  task automatic do_txn(input int m, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input int ack_cyc, input logic [31:0] srd,
                        input logic exp_err, input logic [31:0] exp_rd);
    logic got;
    int   last;
    @(posedge clk); #1;
    m_we[m]    = we;
    m_addr[m]  = addr;
    m_wdata[m] = wdata;
    m_wstrb[m] = strb;
    m_req[m]   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (m_gnt[m]) got = 1'b1;
    end
    chk("txn_grant_seen", got, 1);
    if (!got) begin
      m_req[m] = 1'b0;
      return;
    end
    chk("txn_grant_onehot", m_gnt, (m == 1) ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    m_req[m] = 1'b0;
    last = (ack_cyc == 0) ? TMO : ack_cyc;
    for (int k = 1; k <= last; k++) begin
      if (k == ack_cyc) begin
        s_ack   = 1'b1;
        s_rdata = srd;
      end
      @(negedge clk);
      chk("busy_sreq", s_req, 1);
      chk("busy_flag", busy, 1);
      chk("busy_gnt", m_gnt, 0);
      chk("busy_saddr", s_addr, addr);
      chk("busy_swdata", s_wdata, wdata);
      chk("busy_swe", s_we, we);
      chk("busy_swstrb", s_wstrb, strb);
      @(posedge clk); #1;
      s_ack   = 1'b0;
      s_rdata = '0;
    end
    sbq.push_back('{m, exp_rd, exp_err, cyc});
    @(negedge clk);
    chk("done_sreq", s_req, 0);
    chk("done_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn    = 1'b0;
    m_req   = '0;
    m_we    = '0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    s_ack   = 1'b0;
    s_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("rst");
    @(posedge clk); #1;
    rstn   = 1'b1;
    mon_en = 1'b1;

    // Both masters contend from the first cycle out of reset.
    run_alternation(4);

    do_txn(0, 1'b1, 32'h0000_7000, 32'h0000_0001, 4'hF, 2, 32'h0000_00AA, 1'b0, 32'h0000_00AA);
    do_txn(1, 1'b0, 32'h0000_7010, 32'h0, 4'h0, 1, 32'h0000_0002, 1'b0, 32'h0000_0002);

    // Slave never answers: error response, then a late ack is flagged.
    do_txn(0, 1'b0, 32'h0000_7020, 32'h0, 4'h0, 0, 32'h0, 1'b1, 32'h0);
    chk("pre_late_spurious", spurious, 0);
    @(posedge clk); #1;
    s_ack = 1'b1;
    @(posedge clk); #1;
    s_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_spurious", spurious, 1);

    do_txn(0, 1'b0, 32'h0000_7030, 32'h0, 4'h0, TMO, 32'h5A5A_5A5A, 1'b0, 32'h5A5A_5A5A);

    // Reset during the second BUSY cycle drops the transfer.
    @(posedge clk); #1;
    m_addr[0] = 32'h0000_7040;
    m_we[0]   = 1'b1;
    m_wdata[0] = 32'h1234_5678;
    m_wstrb[0] = 4'h3;
    m_req[0]  = 1'b1;
    begin
      logic got;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        if (m_gnt[0]) got = 1'b1;
      end
      chk("mid_rst_grant_seen", got, 1);
    end
    @(posedge clk); #1;
    m_req = 2'b00;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy_before", busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("mid_rst");
    @(posedge clk); #1;
    rstn = 1'b1;
    run_alternation(2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pending_responses", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
